// File: rtl/if_defs.sv
// Shared definitions for the instruction-fetch stage.
// Holds the FSM state encoding, the internal fetch-action code passed from
// the next-PC decoder to the top level, and the default parameter values.
package if_defs;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } if_state_e;

  // What the stage does on the coming edge.
  typedef enum logic [1:0] {
    ACT_HOLD     = 2'd0,  // pc and IF/ID keep their values
    ACT_REDIRECT = 2'd1,  // load redirect target, bubble IF/ID
    ACT_FAULT    = 2'd2,  // enter FAULT, capture fault address
    ACT_FETCH    = 2'd3   // capture ROM word, pc += 4
  } if_act_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam int          ROM_AW_DEF   = 10;

endpackage

// File: rtl/if_pc_next.sv
// Next-PC select and fault decode for the fetch stage.
// Ports:
//   state_i          current fetch FSM state
//   pc_i             current PC (byte address)
//   stall_i          hazard hold request
//   redirect_valid_i branch/jump taken
//   redirect_pc_i    redirect target (byte address)
//   act_o            action the top level applies on the next edge
//   pc_next_o        PC value to load
//   fault_addr_o     address to record when act_o is ACT_FAULT
module if_pc_next
  import if_defs::*;
#(
  parameter int ROM_AW = ROM_AW_DEF
) (
  input  if_state_e   state_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output if_act_e     act_o,
  output logic [31:0] pc_next_o,
  output logic [31:0] fault_addr_o
);

  logic misaligned;
  logic out_of_range;

  assign misaligned = (redirect_pc_i[1:0] != 2'b00);
  // Any address bit above the ROM word window means the PC walked off the ROM.
  assign out_of_range = ((pc_i >> (ROM_AW + 2)) != 32'd0);

  always_comb begin
    act_o        = ACT_HOLD;
    pc_next_o    = pc_i;
    fault_addr_o = pc_i;
    unique case (state_i)
      ST_BOOT, ST_RUN: begin
        // Redirect outranks stall; BOOT honours redirects but never fetches.
        if (redirect_valid_i) begin
          if (misaligned) begin
            act_o        = ACT_FAULT;
            fault_addr_o = redirect_pc_i;
          end else begin
            act_o     = ACT_REDIRECT;
            pc_next_o = redirect_pc_i;
          end
        end else if (state_i == ST_BOOT || stall_i) begin
          act_o = ACT_HOLD;
        end else if (out_of_range) begin
          act_o = ACT_FAULT;
        end else begin
          act_o     = ACT_FETCH;
          pc_next_o = pc_i + 32'd4;
        end
      end
      default: begin
        act_o = ACT_HOLD;
      end
    endcase
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage in front of the ROM_D instruction memory.
// Owns the PC, drives the ROM word address, and captures the returned word
// into the IF/ID pipeline register. Handles stall, redirect and fetch faults.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             hold PC and IF/ID
//   redirect_valid/pc branch/jump target (priority over stall)
//   rom_a / rom_spo   ROM word address out / read data in (zero latency)
//   if_id_*           IF/ID register: instruction, its PC, PC+4, valid
//   fetch_fault       sticky fault flag (set while in FAULT)
//   fault_pc          offending address
//   fetch_count       instructions delivered to IF/ID (wraps)
//
// state | meaning
// BOOT  | first cycle after reset, no fetch, redirect honoured
// RUN   | normal fetch
// FAULT | terminal until reset, IF/ID held as bubble
module if_fetch_stage
  import if_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ROM_AW   = ROM_AW_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [31:0]       rom_spo,
  output logic [31:0]       if_id_inst,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_pc4,
  output logic              if_id_valid,
  output logic              fetch_fault,
  output logic [31:0]       fault_pc,
  output logic [31:0]       fetch_count
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic        valid_q, valid_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;

  if_act_e     act;
  logic [31:0] pc_next;
  logic [31:0] fault_addr;

  if_pc_next #(
    .ROM_AW (ROM_AW)
  ) u_pc_next (
    .state_i          (state_q),
    .pc_i             (pc_q),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .act_o            (act),
    .pc_next_o        (pc_next),
    .fault_addr_o     (fault_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      ifpc_q     <= 32'd0;
      ifpc4_q    <= 32'd0;
      valid_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      ifpc_q     <= ifpc_d;
      ifpc4_q    <= ifpc4_d;
      valid_q    <= valid_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    ifpc_d     = ifpc_q;
    ifpc4_d    = ifpc4_q;
    valid_d    = valid_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;

    unique case (act)
      ACT_FAULT: begin
        state_d    = ST_FAULT;
        fault_pc_d = fault_addr;
        inst_d     = NOP_INST;
        valid_d    = 1'b0;
      end
      ACT_REDIRECT: begin
        pc_d    = pc_next;
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
      ACT_FETCH: begin
        pc_d    = pc_next;
        inst_d  = rom_spo;
        ifpc_d  = pc_q;
        ifpc4_d = pc_q + 32'd4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end
      default: begin
        // Hold; FAULT keeps re-asserting the bubble.
        if (state_q == ST_FAULT) begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
      end
    endcase

    // BOOT lasts exactly one cycle unless a bad redirect faults it.
    if (state_q == ST_BOOT && act != ACT_FAULT) begin
      state_d = ST_RUN;
    end
  end

  assign rom_a       = pc_q[ROM_AW+1:2];
  assign if_id_inst  = inst_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_pc4   = ifpc4_q;
  assign if_id_valid = valid_q;
  assign fetch_fault = (state_q == ST_FAULT);
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a ROM model returning 1000_0000 | addr.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  rom_a;
  logic [31:0] rom_spo;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int vectors;
  int miscompares;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_a          (rom_a),
    .rom_spo        (rom_spo),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count)
  );

  assign rom_spo = 32'h1000_0000 | {22'd0, rom_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;

    // 1. reset and free-run
    step();
    step();
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_inst", if_id_inst, 32'h0);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_rom_a", {22'd0, rom_a}, 32'd0);
    rst = 1'b0;
    step();
    chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
    chk("boot_count", fetch_count, 32'd0);
    step();
    chk("f0_inst", if_id_inst, 32'h1000_0000);
    chk("f0_pc", if_id_pc, 32'h0);
    chk("f0_pc4", if_id_pc4, 32'h4);
    chk("f0_valid", {31'd0, if_id_valid}, 32'd1);
    step();
    chk("f1_inst", if_id_inst, 32'h1000_0001);
    chk("f1_pc", if_id_pc, 32'h4);
    step();
    chk("f2_inst", if_id_inst, 32'h1000_0002);
    chk("f2_pc", if_id_pc, 32'h8);
    chk("f2_count", fetch_count, 32'd3);
    chk("f2_rom_a", {22'd0, rom_a}, 32'd3);

    // 2. stall for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", if_id_pc, 32'h8);
      chk("stall_inst", if_id_inst, 32'h1000_0002);
      chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
      chk("stall_count", fetch_count, 32'd3);
      chk("stall_rom_a", {22'd0, rom_a}, 32'd3);
    end
    stall = 1'b0;
    step();
    chk("unstall_pc", if_id_pc, 32'hC);
    chk("unstall_inst", if_id_inst, 32'h1000_0003);
    chk("unstall_count", fetch_count, 32'd4);

    // 3. redirect wins over stall
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir_inst", if_id_inst, 32'h0);
    chk("redir_pc_hold", if_id_pc, 32'hC);
    chk("redir_count", fetch_count, 32'd4);
    chk("redir_rom_a", {22'd0, rom_a}, 32'h40);
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    chk("tgt_pc", if_id_pc, 32'h100);
    chk("tgt_inst", if_id_inst, 32'h1000_0040);
    chk("tgt_pc4", if_id_pc4, 32'h104);
    chk("tgt_count", fetch_count, 32'd5);

    // 4. misaligned redirect faults; later redirects are ignored
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h102);
    chk("mis_valid", {31'd0, if_id_valid}, 32'd0);
    redirect_pc = 32'h0;
    step();
    chk("ign_fault", {31'd0, fetch_fault}, 32'd1);
    chk("ign_fault_pc", fault_pc, 32'h102);
    chk("ign_valid", {31'd0, if_id_valid}, 32'd0);
    chk("ign_count", fetch_count, 32'd5);
    chk("ign_rom_a", {22'd0, rom_a}, 32'h41);
    redirect_valid = 1'b0;
    step();
    chk("frz_rom_a", {22'd0, rom_a}, 32'h41);
    chk("frz_inst", if_id_inst, 32'h0);

    // 5. end of ROM, redirect applied during BOOT
    rst = 1'b1;
    step();
    chk("rst2_fault", {31'd0, fetch_fault}, 32'd0);
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFC;
    step();
    chk("eor_rom_a", {22'd0, rom_a}, 32'h3FF);
    chk("eor_valid", {31'd0, if_id_valid}, 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("last_inst", if_id_inst, 32'h1000_03FF);
    chk("last_pc", if_id_pc, 32'hFFC);
    chk("last_pc4", if_id_pc4, 32'h1000);
    chk("last_count", fetch_count, 32'd1);
    step();
    chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
    chk("oor_fault_pc", fault_pc, 32'h1000);
    chk("oor_valid", {31'd0, if_id_valid}, 32'd0);
    chk("oor_inst", if_id_inst, 32'h0);
    chk("oor_count", fetch_count, 32'd1);

    // reset wins even with stall and redirect asserted
    rst = 1'b1;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    chk("fin_fault", {31'd0, fetch_fault}, 32'd0);
    chk("fin_rom_a", {22'd0, rom_a}, 32'd0);
    chk("fin_fault_pc", fault_pc, 32'h0);
    chk("fin_count", fetch_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the ROM_D instruction memory (10-bit word address, 32-bit combinational read data, zero read latency). It owns the PC and drives ROM_D's address. It captures the returned word into the IF/ID pipeline register and handles stall, branch/jump redirect, and fetch faults. It also exposes a delivered-instruction counter for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
ROM_AW, 10, ROM word-address width; fetchable byte space is 0 .. 4*2^ROM_AW-1.
NOP_INST, 32'h0000_0000, bubble instruction (MIPS sll $0,$0,0).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard-unit hold request; PC and IF/ID both hold.
redirect_valid  in  1  branch/jump taken; takes priority over stall.
redirect_pc  in  32  target byte address.
rom_a  out  ROM_AW  to ROM_D .a; equals pc[ROM_AW+1:2], combinational.
rom_spo  in  32  from ROM_D .spo.
if_id_inst  out  32  registered instruction.
if_id_pc  out  32  registered PC of if_id_inst.
if_id_pc4  out  32  registered if_id_pc+4.
if_id_valid  out  1  IF/ID holds a real instruction.
fetch_fault  out  1  sticky fault flag.
fault_pc  out  32  offending address.
fetch_count  out  32  number of instructions delivered to IF/ID.

Behaviour:
- Reset values: pc=RESET_PC, state=BOOT, if_id_inst=NOP_INST, if_id_pc=0, if_id_pc4=0, if_id_valid=0, fetch_fault=0, fault_pc=0, fetch_count=0. Reset overrides every other input.
- FSM states:
  - BOOT: one cycle; no fetch, IF/ID keeps its bubble, pc holds; next state RUN. Redirect in BOOT is applied as in RUN.
  - RUN: normal fetch.
  - FAULT: terminal until rst.
- RUN priority, highest first:
  1. redirect_valid=1 with redirect_pc[1:0]!=0: state←FAULT, fault_pc←redirect_pc, IF/ID←bubble.
  2. redirect_valid=1, aligned: pc←redirect_pc, IF/ID←bubble (inst=NOP_INST, valid=0, pc/pc4 hold). Applies even when stall=1.
  3. stall=1: pc and all IF/ID outputs hold, fetch_count holds.
  4. pc[31:ROM_AW+2]!=0 (out of range): state←FAULT, fault_pc←pc, IF/ID←bubble.
  5. Otherwise: if_id_inst←rom_spo, if_id_pc←pc, if_id_pc4←pc+4, if_id_valid←1, pc←pc+4, fetch_count←fetch_count+1.
- Latency: the instruction at pc appears on if_id_inst one edge after pc is presented. Throughput is one per cycle with no stall.
- FAULT: pc frozen, IF/ID bubble every cycle, fetch_fault=1, fault_pc held. stall and redirect are ignored.
- Arithmetic: pc+4 is a 32-bit add that wraps modulo 2^32. Sequential fetch past the last ROM word faults on the next cycle (rule 4); it does not wrap to 0. fetch_count wraps modulo 2^32.
- rom_a is driven from pc in every state, including FAULT, but is only meaningful in RUN.
- rst asserted mid-stall or mid-redirect: reset values win on that edge.

Decomposition:
- Shared package/header if_defs: FSM encodings (BOOT=2'd0, RUN=2'd1, FAULT=2'd2), NOP_INST, RESET_PC.
- One natural sub-module, if_pc_next: combinational next-PC select (redirect / hold / +4) plus the fault-detect decode.
- The top level holds the PC register, FSM, IF/ID register and counter.

Test Plan:
Bench ROM model: rom_spo = 32'h1000_0000 | rom_a.
1. Reset and free-run: rst high 2 cycles, then low. The BOOT cycle shows valid=0. Next 3 edges: if_id_inst=1000_0000/1000_0001/1000_0002, if_id_pc=0/4/8, fetch_count=3.
2. Stall: stall=1 for 3 cycles while if_id_pc=8. IF/ID, pc and fetch_count are unchanged. On release, if_id_pc=C and if_id_inst=1000_0003.
3. Redirect during stall: stall=1 and redirect_valid=1 with redirect_pc=0x100 on the same edge. Next cycle: valid=0, inst=0. Following edge: if_id_pc=0x100, if_id_inst=1000_0040.
4. Misaligned redirect to 0x102: fetch_fault=1, fault_pc=0x102, valid stays 0. Later redirect to 0x0 is ignored.
5. End of ROM: redirect to 0xFFC. Inst 1000_03FF is delivered. Next cycle: fault with fault_pc=0x1000. Then rst clears fetch_fault to 0 and pc to 0.
